dhs_axil_apb_router: RTL and testbench
======================================

Name: dhs_axil_apb_router

Overview:
Parametrised AXI-Lite slave to multi-target APB master bridge with a built-in address decoder, generalising the fixed peripheral address map into a configurable rule table. Sits behind the peripheral link and fans out to NUM_SLV APB peripherals (SoC ctrl, SPI CSR, UART, CLINT, PLIC, DMA, ...). Adds behaviour the static map lacks: decode-error responses, per-access APB timeout, and fair read/write arbitration.

Parameters:
NUM_SLV, 6, number of APB targets (1..16)
NUM_RULES, 8, number of address rules
ADDRW, 32, address width
DATAW, 32, data width (32 or 64); STRBW = DATAW/8
RULE_IDX, packed NUM_RULES x 4 bits, target index per rule
RULE_START, packed NUM_RULES x ADDRW, inclusive start address per rule
RULE_END, packed NUM_RULES x ADDRW, inclusive end address per rule
TIMEOUT, 256, max ACCESS cycles before abort; 0 disables timeout

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
s_aw_addr_i  in  ADDRW  write address
s_aw_prot_i  in  3  write protection
s_aw_valid_i / s_aw_ready_o  in/out  1  AW handshake
s_w_data_i  in  DATAW  write data
s_w_strb_i  in  STRBW  write strobes
s_w_valid_i / s_w_ready_o  in/out  1  W handshake
s_b_resp_o  out  2  write response
s_b_valid_o / s_b_ready_i  out/in  1  B handshake
s_ar_addr_i  in  ADDRW  read address
s_ar_prot_i  in  3  read protection
s_ar_valid_i / s_ar_ready_o  in/out  1  AR handshake
s_r_data_o  out  DATAW  read data
s_r_resp_o  out  2  read response
s_r_valid_o / s_r_ready_i  out/in  1  R handshake
m_paddr_o  out  ADDRW  APB address
m_pprot_o  out  3  APB protection
m_pwrite_o  out  1  APB direction
m_pwdata_o  out  DATAW  APB write data
m_pstrb_o  out  STRBW  APB strobes (0 on reads)
m_psel_o  out  NUM_SLV  one-hot select
m_penable_o  out  1  APB enable
m_prdata_i  in  NUM_SLV*DATAW  per-target read data
m_pready_i  in  NUM_SLV  per-target ready
m_pslverr_i  in  NUM_SLV  per-target error

Behaviour:
- Reset (async assert, sync deassert assumed upstream): all ready/valid/psel/penable = 0, all data/addr/resp outputs = 0, FSM = IDLE, arbitration favours write. In-flight transaction dropped, no response issued.
- FSM: IDLE -> SETUP -> ACCESS -> RESP -> IDLE; IDLE -> RESP directly on decode miss.
- IDLE: write candidate needs s_aw_valid_i AND s_w_valid_i together; read candidate needs s_ar_valid_i. One pending kind -> grant it. Both pending -> grant the kind not granted last (round-robin). Grant pulses aw_ready+w_ready together (write) or ar_ready (read) for exactly one cycle; addr/data/strb/prot latched.
- Decode: addr matched against every rule, inclusive [START, END]; lowest-numbered matching rule wins on overlap. Hit -> SETUP with psel[RULE_IDX] = 1. Miss -> RESP with resp DECERR (2'b11), rdata 0, no APB activity. RULE_IDX >= NUM_SLV treated as miss.
- SETUP (1 cycle): psel asserted, penable 0, paddr/pwrite/pwdata/pstrb/pprot stable.
- ACCESS: penable 1; hold until selected pready = 1, then capture prdata, resp = pslverr ? SLVERR (2'b10) : OKAY (2'b00); deassert psel/penable next cycle; go RESP.
- Timeout: counter cleared on SETUP entry, increments each ACCESS cycle; when TIMEOUT cycles elapse without pready, abort: psel/penable drop, resp SLVERR, rdata 0. pready arriving in the same cycle as expiry wins (normal completion).
- RESP: b_valid (write) or r_valid (read) held with stable resp/data until matching ready; then IDLE. No new grant while in RESP (one outstanding transaction).
- Minimum latency with pready=1 on first ACCESS cycle: grant at cycle 0, psel cycle 1, penable cycle 2, b/r_valid cycle 3.
- Unselected targets' prdata/pready/pslverr ignored.

Test Plan:
- Rule 2 = UART 0x2000_1000..0x2000_1FFF at idx 2; write 0xA5A5_A5A5 strb 0xF to 0x2000_1004, pready=1 -> psel=6'b000100 cycle 1, penable cycle 2, bresp 2'b00 cycle 3.
- Read 0x1000_0000 (no rule) -> no psel, rresp 2'b11, rdata 0.
- Read UART with pready held 0, TIMEOUT=16 -> abort after 16 ACCESS cycles, rresp 2'b10; with pready rising on the 16th cycle -> OKAY and captured prdata.
- Simultaneous write and read valid for 4 transactions -> grant order W, R, W, R.
- Overlap: rule 0 idx 0 and rule 1 idx 1 both covering 0x2000_0000 -> psel[0] only; pslverr=1 -> SLVERR.
- s_r_ready_i low 5 cycles in RESP -> r_valid/data stable, no new grant; rst_ni pulsed mid-ACCESS -> all outputs 0 immediately, next transaction completes normally.

Source files
------------

// File: rtl/dhs_axil_apb_router.sv
// dhs_axil_apb_router: AXI-Lite slave to multi-target APB master bridge with rule-table decode,
// decode-error responses, per-access timeout and round-robin read/write arbitration.
module dhs_axil_apb_router #(
  parameter int NUM_SLV = 6,
  parameter int NUM_RULES = 8,
  parameter int ADDRW = 32,
  parameter int DATAW = 32,
  parameter logic [NUM_RULES*4-1:0] RULE_IDX = 32'hFF54_3210,
  parameter logic [NUM_RULES*ADDRW-1:0] RULE_START = {
    32'h2000_7000, 32'h2000_6000, 32'h2000_5000, 32'h2000_4000,
    32'h2000_3000, 32'h2000_2000, 32'h2000_1000, 32'h2000_0000},
  parameter logic [NUM_RULES*ADDRW-1:0] RULE_END = {
    32'h2000_7FFF, 32'h2000_6FFF, 32'h2000_5FFF, 32'h2000_4FFF,
    32'h2000_3FFF, 32'h2000_2FFF, 32'h2000_1FFF, 32'h2000_0FFF},
  parameter int TIMEOUT = 256,
  localparam int STRBW = DATAW / 8
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic [ADDRW-1:0]         s_aw_addr_i,
  input  logic [2:0]               s_aw_prot_i,
  input  logic                     s_aw_valid_i,
  output logic                     s_aw_ready_o,
  input  logic [DATAW-1:0]         s_w_data_i,
  input  logic [STRBW-1:0]         s_w_strb_i,
  input  logic                     s_w_valid_i,
  output logic                     s_w_ready_o,
  output logic [1:0]               s_b_resp_o,
  output logic                     s_b_valid_o,
  input  logic                     s_b_ready_i,
  input  logic [ADDRW-1:0]         s_ar_addr_i,
  input  logic [2:0]               s_ar_prot_i,
  input  logic                     s_ar_valid_i,
  output logic                     s_ar_ready_o,
  output logic [DATAW-1:0]         s_r_data_o,
  output logic [1:0]               s_r_resp_o,
  output logic                     s_r_valid_o,
  input  logic                     s_r_ready_i,
  output logic [ADDRW-1:0]         m_paddr_o,
  output logic [2:0]               m_pprot_o,
  output logic                     m_pwrite_o,
  output logic [DATAW-1:0]         m_pwdata_o,
  output logic [STRBW-1:0]         m_pstrb_o,
  output logic [NUM_SLV-1:0]       m_psel_o,
  output logic                     m_penable_o,
  input  logic [NUM_SLV*DATAW-1:0] m_prdata_i,
  input  logic [NUM_SLV-1:0]       m_pready_i,
  input  logic [NUM_SLV-1:0]       m_pslverr_i
);
  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;
  localparam int TW = $clog2(TIMEOUT + 2);
  state_t state_q, state_d;
  logic is_wr_q, last_wr_q;
  logic [ADDRW-1:0] addr_q;
  logic [DATAW-1:0] wdata_q, rdata_q, sel_rdata;
  logic [STRBW-1:0] strb_q;
  logic [2:0] prot_q;
  logic [NUM_SLV-1:0] sel_q, hit_oh;
  logic [1:0] resp_q;
  logic [TW-1:0] tcnt_q;
  logic idle, arb_w, grant_w, grant_r, match, hit, sel_rdy, sel_err, tout;
  logic [3:0] hit_idx;
  logic [ADDRW-1:0] dec_addr;
  // write wins a tie only if the previous grant was a read; last_wr_q resets low so writes go first
  assign idle = rst_ni && state_q == IDLE;
  assign arb_w = s_aw_valid_i && s_w_valid_i && (!s_ar_valid_i || !last_wr_q);
  assign grant_w = idle && arb_w;
  assign grant_r = idle && s_ar_valid_i && !arb_w;
  assign dec_addr = arb_w ? s_aw_addr_i : s_ar_addr_i;
  // scan high to low so the lowest-numbered matching rule is the one left standing
  always_comb begin
    match = 1'b0;
    hit_idx = '0;
    for (int r = NUM_RULES - 1; r >= 0; r--)
      if (dec_addr >= RULE_START[r*ADDRW +: ADDRW] && dec_addr <= RULE_END[r*ADDRW +: ADDRW]) begin
        match = 1'b1;
        hit_idx = RULE_IDX[r*4 +: 4];
      end
    hit = match && ({1'b0, hit_idx} < 5'(NUM_SLV));
    hit_oh = hit ? NUM_SLV'(1) << hit_idx : '0;
  end
  always_comb begin
    sel_rdata = '0;
    for (int s = 0; s < NUM_SLV; s++)
      if (sel_q[s]) sel_rdata = sel_rdata | m_prdata_i[s*DATAW +: DATAW];
  end
  assign sel_rdy = |(sel_q & m_pready_i);
  assign sel_err = |(sel_q & m_pslverr_i);
  assign tout = (TIMEOUT != 0) && tcnt_q == TW'(TIMEOUT - 1);
  always_comb begin
    state_d = state_q;
    state_d = state_q == IDLE ? ((grant_w || grant_r) ? (hit ? SETUP : RESP) : IDLE) :
              state_q == SETUP ? ACCESS :
              state_q == ACCESS ? ((sel_rdy || tout) ? RESP : ACCESS) :
              ((is_wr_q ? s_b_ready_i : s_r_ready_i) ? IDLE : RESP);
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      is_wr_q <= 1'b0;
      last_wr_q <= 1'b0;
      addr_q <= '0;
      wdata_q <= '0;
      strb_q <= '0;
      prot_q <= '0;
      sel_q <= '0;
      resp_q <= '0;
      rdata_q <= '0;
      tcnt_q <= '0;
    end else begin
      state_q <= state_d;
      if (grant_w || grant_r) begin
        is_wr_q <= grant_w;
        last_wr_q <= grant_w;
        addr_q <= dec_addr;
        prot_q <= grant_w ? s_aw_prot_i : s_ar_prot_i;
        wdata_q <= grant_w ? s_w_data_i : '0;
        strb_q <= grant_w ? s_w_strb_i : '0;
        sel_q <= hit_oh;
        resp_q <= hit ? 2'b00 : 2'b11;
        rdata_q <= '0;
        tcnt_q <= '0;
      end else if (state_q == ACCESS) begin
        if (sel_rdy) begin
          resp_q <= sel_err ? 2'b10 : 2'b00;
          rdata_q <= is_wr_q ? '0 : sel_rdata;
        end else if (tout) begin
          resp_q <= 2'b10;
          rdata_q <= '0;
        end else
          tcnt_q <= tcnt_q + 1'b1;
      end
    end
  end
  assign s_aw_ready_o = grant_w;
  assign s_w_ready_o = grant_w;
  assign s_ar_ready_o = grant_r;
  assign s_b_valid_o = state_q == RESP && is_wr_q;
  assign s_r_valid_o = state_q == RESP && !is_wr_q;
  assign s_b_resp_o = resp_q;
  assign s_r_resp_o = resp_q;
  assign s_r_data_o = rdata_q;
  assign m_paddr_o = addr_q;
  assign m_pprot_o = prot_q;
  assign m_pwrite_o = is_wr_q;
  assign m_pwdata_o = wdata_q;
  assign m_pstrb_o = strb_q;
  assign m_psel_o = (state_q == SETUP || state_q == ACCESS) ? sel_q : '0;
  assign m_penable_o = state_q == ACCESS;
endmodule

// File: tb/tb_dhs_axil_apb_router.sv
// tb_dhs_axil_apb_router: directed checks of decode, APB timing, timeout, arbitration and reset.
module tb_dhs_axil_apb_router;
  logic clk_i = 1'b0;
  logic rst_ni;
  logic [31:0] s_aw_addr_i, s_w_data_i, s_ar_addr_i, s_r_data_o, m_paddr_o, m_pwdata_o;
  logic [2:0] s_aw_prot_i, s_ar_prot_i, m_pprot_o;
  logic [3:0] s_w_strb_i, m_pstrb_o;
  logic s_aw_valid_i, s_aw_ready_o, s_w_valid_i, s_w_ready_o, s_b_valid_o, s_b_ready_i;
  logic s_ar_valid_i, s_ar_ready_o, s_r_valid_o, s_r_ready_i, m_pwrite_o, m_penable_o;
  logic [1:0] s_b_resp_o, s_r_resp_o;
  logic [5:0] m_psel_o, m_pready_i, m_pslverr_i;
  logic [191:0] m_prdata_i;
  int total = 0, bad = 0;
  logic [5:0] ps;
  logic [1:0] rs;
  logic [31:0] q;
  logic [6:0] at_r;
  logic [3:0] g;
  int n, k;

  always #5 clk_i = ~clk_i;

  dhs_axil_apb_router #(
    .NUM_SLV(6), .NUM_RULES(4), .ADDRW(32), .DATAW(32),
    .RULE_IDX({4'd7, 4'd2, 4'd1, 4'd0}),
    .RULE_START({32'h3000_0000, 32'h2000_1000, 32'h2000_0000, 32'h2000_0000}),
    .RULE_END({32'h3000_0FFF, 32'h2000_1FFF, 32'h2000_0FFF, 32'h2000_00FF}),
    .TIMEOUT(16)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .s_aw_addr_i(s_aw_addr_i), .s_aw_prot_i(s_aw_prot_i), .s_aw_valid_i(s_aw_valid_i), .s_aw_ready_o(s_aw_ready_o),
    .s_w_data_i(s_w_data_i), .s_w_strb_i(s_w_strb_i), .s_w_valid_i(s_w_valid_i), .s_w_ready_o(s_w_ready_o),
    .s_b_resp_o(s_b_resp_o), .s_b_valid_o(s_b_valid_o), .s_b_ready_i(s_b_ready_i),
    .s_ar_addr_i(s_ar_addr_i), .s_ar_prot_i(s_ar_prot_i), .s_ar_valid_i(s_ar_valid_i), .s_ar_ready_o(s_ar_ready_o),
    .s_r_data_o(s_r_data_o), .s_r_resp_o(s_r_resp_o), .s_r_valid_o(s_r_valid_o), .s_r_ready_i(s_r_ready_i),
    .m_paddr_o(m_paddr_o), .m_pprot_o(m_pprot_o), .m_pwrite_o(m_pwrite_o), .m_pwdata_o(m_pwdata_o),
    .m_pstrb_o(m_pstrb_o), .m_psel_o(m_psel_o), .m_penable_o(m_penable_o),
    .m_prdata_i(m_prdata_i), .m_pready_i(m_pready_i), .m_pslverr_i(m_pslverr_i)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  // one full transaction; target pready follows rdy_lo until cycle rdy_at, then all ones
  task automatic xact(input bit w, input logic [31:0] a, input logic [31:0] d, input int rdy_at,
                      input logic [5:0] rdy_lo, output logic [5:0] ps_o, output logic [1:0] rs_o,
                      output logic [31:0] q_o, output int n_o, output logic [6:0] at_o);
    logic done, gnt;
    done = 0; gnt = 0; ps_o = '0; rs_o = '0; q_o = '0; n_o = 0; at_o = '0;
    s_aw_addr_i = a; s_ar_addr_i = a; s_w_data_i = d; s_w_strb_i = 4'hF;
    s_aw_valid_i = w; s_w_valid_i = w; s_ar_valid_i = !w; s_b_ready_i = 1; s_r_ready_i = 1;
    while (!done && n_o < 64) begin
      m_pready_i = (n_o >= rdy_at) ? 6'h3F : rdy_lo;
      @(negedge clk_i);
      ps_o = ps_o | m_psel_o;
      if (w ? s_aw_ready_o : s_ar_ready_o) gnt = 1;
      if (w ? s_b_valid_o : s_r_valid_o) begin
        done = 1;
        rs_o = w ? s_b_resp_o : s_r_resp_o;
        q_o = s_r_data_o;
        at_o = {m_psel_o, m_penable_o};
      end
      step();
      if (gnt) begin s_aw_valid_i = 0; s_w_valid_i = 0; s_ar_valid_i = 0; end
      if (!done) n_o++;
    end
    if (!done) chk("xact_no_response", 0, 1);
    s_aw_valid_i = 0; s_w_valid_i = 0; s_ar_valid_i = 0; s_b_ready_i = 0; s_r_ready_i = 0;
    m_pready_i = 6'h3F;
  endtask

  initial begin
    rst_ni = 0;
    s_aw_addr_i = '0; s_aw_prot_i = 3'd2; s_aw_valid_i = 0; s_w_data_i = '0; s_w_strb_i = '0; s_w_valid_i = 0;
    s_b_ready_i = 0; s_ar_addr_i = '0; s_ar_prot_i = 3'd1; s_ar_valid_i = 0; s_r_ready_i = 0;
    m_pready_i = 6'h3F; m_pslverr_i = '0;
    for (int s = 0; s < 6; s++) m_prdata_i[s*32 +: 32] = 32'hDA7A_0000 + s;
    #2;
    chk("rst_ready", {s_aw_ready_o, s_w_ready_o, s_ar_ready_o}, 0);
    chk("rst_valid", {s_b_valid_o, s_r_valid_o}, 0);
    chk("rst_apb", {m_psel_o, m_penable_o, m_pwrite_o}, 0);
    chk("rst_data", {m_paddr_o, m_pwdata_o}, 0);
    chk("rst_resp", {s_b_resp_o, s_r_resp_o, s_r_data_o}, 0);
    repeat (3) @(posedge clk_i);
    #2 rst_ni = 1;
    step();

    // both kinds pending back to back: write first after reset, then alternate
    s_aw_addr_i = 32'h2000_1000; s_ar_addr_i = 32'h2000_1000; s_w_data_i = 32'h1;
    s_aw_valid_i = 1; s_w_valid_i = 1; s_ar_valid_i = 1; s_b_ready_i = 1; s_r_ready_i = 1;
    k = 0; g = '0;
    for (int c = 0; c < 40 && k < 4; c++) begin
      @(negedge clk_i);
      if (s_aw_ready_o || s_ar_ready_o) begin
        chk("arb_exclusive", s_aw_ready_o & s_ar_ready_o, 0);
        g[k] = s_aw_ready_o;
        k++;
      end
      step();
    end
    s_aw_valid_i = 0; s_w_valid_i = 0; s_ar_valid_i = 0;
    chk("arb_count", k, 4);
    chk("arb_g0_w", g[0], 1);
    chk("arb_g1_r", g[1], 0);
    chk("arb_g2_w", g[2], 1);
    chk("arb_g3_r", g[3], 0);
    repeat (4) step();
    s_b_ready_i = 0; s_r_ready_i = 0;

    // UART write, cycle-exact APB phases
    s_aw_addr_i = 32'h2000_1004; s_w_data_i = 32'hA5A5_A5A5; s_w_strb_i = 4'hF;
    s_aw_valid_i = 1; s_w_valid_i = 1; s_b_ready_i = 1;
    @(negedge clk_i);
    chk("wr_c0_ready", {s_aw_ready_o, s_w_ready_o, s_ar_ready_o}, 3'b110);
    chk("wr_c0_psel", m_psel_o, 0);
    step();
    s_aw_valid_i = 0; s_w_valid_i = 0;
    @(negedge clk_i);
    chk("wr_c1_psel", m_psel_o, 6'b000100);
    chk("wr_c1_penable", m_penable_o, 0);
    chk("wr_c1_apb", {m_paddr_o, m_pwdata_o, m_pstrb_o, m_pwrite_o, m_pprot_o}, {32'h2000_1004, 32'hA5A5_A5A5, 4'hF, 1'b1, 3'd2});
    step();
    @(negedge clk_i);
    chk("wr_c2_access", {m_psel_o, m_penable_o}, {6'b000100, 1'b1});
    step();
    @(negedge clk_i);
    chk("wr_c3_b", {s_b_valid_o, s_b_resp_o, m_psel_o, m_penable_o}, {1'b1, 2'b00, 6'b0, 1'b0});
    step();
    @(negedge clk_i);
    chk("wr_c4_b_done", s_b_valid_o, 0);
    step();
    s_b_ready_i = 0;

    xact(0, 32'h1000_0000, 0, 0, 6'h3F, ps, rs, q, n, at_r);
    chk("miss_psel", ps, 0);
    chk("miss_resp_data", {rs, q}, {2'b11, 32'h0});
    chk("miss_latency", n, 1);

    xact(0, 32'h3000_0004, 0, 0, 6'h3F, ps, rs, q, n, at_r);
    chk("badidx_psel", ps, 0);
    chk("badidx_resp", rs, 2'b11);

    xact(0, 32'h2000_1FFF, 0, 0, 6'h3F, ps, rs, q, n, at_r);
    chk("end_incl_psel", ps, 6'b000100);
    chk("end_incl_rd", {rs, q}, {2'b00, 32'hDA7A_0002});
    chk("end_incl_latency", n, 3);

    xact(0, 32'h2000_2000, 0, 0, 6'h3F, ps, rs, q, n, at_r);
    chk("past_end_resp", {ps, rs}, {6'b0, 2'b11});

    m_pslverr_i = 6'b000001;
    xact(1, 32'h2000_0000, 32'h55, 0, 6'h3F, ps, rs, q, n, at_r);
    chk("overlap_psel", ps, 6'b000001);
    chk("overlap_slverr", rs, 2'b10);
    xact(0, 32'h2000_0100, 0, 0, 6'h3F, ps, rs, q, n, at_r);
    chk("rule1_psel", ps, 6'b000010);
    chk("rule1_rd", {rs, q}, {2'b00, 32'hDA7A_0001});
    m_pslverr_i = '0;

    // target 2 silent while others are ready
    xact(0, 32'h2000_1000, 0, 1000, 6'b111011, ps, rs, q, n, at_r);
    chk("tout_resp_data", {rs, q}, {2'b10, 32'h0});
    chk("tout_latency", n, 18);
    chk("tout_apb_idle", at_r, 0);

    xact(0, 32'h2000_1000, 0, 17, 6'b111011, ps, rs, q, n, at_r);
    chk("late_rdy_rd", {rs, q}, {2'b00, 32'hDA7A_0002});
    chk("late_rdy_latency", n, 18);

    // R backpressure with a write waiting
    s_ar_addr_i = 32'h2000_1008; s_ar_valid_i = 1; s_r_ready_i = 0;
    @(negedge clk_i);
    chk("bp_grant", s_ar_ready_o, 1);
    step();
    s_ar_valid_i = 0;
    s_aw_addr_i = 32'h2000_1000; s_aw_valid_i = 1; s_w_valid_i = 1;
    @(negedge clk_i);
    chk("bp_rd_strb_dir", {m_pstrb_o, m_pwrite_o, m_pprot_o}, {4'h0, 1'b0, 3'd1});
    step();
    step();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk_i);
      chk("bp_hold", {s_r_valid_o, s_r_resp_o, s_r_data_o}, {1'b1, 2'b00, 32'hDA7A_0002});
      chk("bp_no_grant", {s_aw_ready_o, s_ar_ready_o}, 0);
      step();
    end
    s_aw_valid_i = 0; s_w_valid_i = 0; s_r_ready_i = 1;
    @(negedge clk_i);
    chk("bp_release_valid", s_r_valid_o, 1);
    step();
    s_r_ready_i = 0;
    @(negedge clk_i);
    chk("bp_done", s_r_valid_o, 0);
    step();

    // reset while stuck in ACCESS
    m_pready_i = 6'b111011;
    s_aw_addr_i = 32'h2000_1000; s_w_data_i = 32'hCAFE_F00D; s_aw_valid_i = 1; s_w_valid_i = 1; s_b_ready_i = 1;
    step();
    s_aw_valid_i = 0; s_w_valid_i = 0;
    step();
    @(negedge clk_i);
    chk("pre_rst_access", {m_psel_o, m_penable_o}, {6'b000100, 1'b1});
    #2 rst_ni = 0;
    #1;
    chk("mid_rst_apb", {m_psel_o, m_penable_o, m_pwrite_o, m_pstrb_o}, 0);
    chk("mid_rst_data", {m_paddr_o, m_pwdata_o}, 0);
    chk("mid_rst_axi", {s_b_valid_o, s_r_valid_o, s_aw_ready_o, s_ar_ready_o}, 0);
    repeat (2) @(posedge clk_i);
    #2 rst_ni = 1;
    s_b_ready_i = 0;
    m_pready_i = 6'h3F;
    step();
    xact(0, 32'h2000_1000, 0, 0, 6'h3F, ps, rs, q, n, at_r);
    chk("post_rst_rd", {ps, rs, q}, {6'b000100, 2'b00, 32'hDA7A_0002});
    chk("post_rst_latency", n, 3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
